// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory controller: IDLE/BUSY/DONE FSM with a LATENCY-cycle stall per access.
// Optional one-entry posted write buffer selected by `define DMEM_WBUF_EN.
module data_memory_ctrl #(
   parameter int unsigned LATENCY    = 3,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemReady
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

   logic [31:0]           mem [DEPTH];
   stateT                 state;
   logic [3:0]            count;
   logic [DEPTH_LOG2-1:0] addrQ;
   logic [31:0]           dataQ;
   logic                  writeQ;

   logic                  request;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic                  startAccess;
   logic                  idleReady;
   logic                  memWe;
   logic [DEPTH_LOG2-1:0] memWAddr;
   logic [31:0]           memWData;
   logic                  unusedAddrBits;

   assign request        = MemReadM | MemWriteM;
   assign wordIdx        = ALUOutM[DEPTH_LOG2+1:2];
   assign unusedAddrBits = ^{ALUOutM[31:DEPTH_LOG2+2], ALUOutM[1:0]};

`ifdef DMEM_WBUF_EN
   logic                  wbValid;
   logic [3:0]            wbCount;
   logic [DEPTH_LOG2-1:0] wbAddr;
   logic [31:0]           wbData;
   logic                  wbCapture;
   logic                  wbCommit;

   // Writes never enter the FSM; every access waits until the buffer has drained.
   assign wbCapture   = (state == StIdle) && MemWriteM && !wbValid;
   assign wbCommit    = wbValid && (wbCount == 4'd0);
   assign startAccess = (state == StIdle) && MemReadM && !MemWriteM && !wbValid;
   assign idleReady   = !request || wbCapture;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbValid <= 1'b0;
         wbCount <= 4'd0;
         wbAddr  <= '0;
         wbData  <= '0;
      end else if (wbCapture) begin
         wbValid <= 1'b1;
         wbCount <= 4'(LATENCY);
         wbAddr  <= wordIdx;
         wbData  <= WriteDataM;
      end else if (wbValid) begin
         if (wbCount == 4'd0) wbValid <= 1'b0;
         else                 wbCount <= wbCount - 4'd1;
      end
   end

   assign memWe    = reset && (wbCommit || ((state == StDone) && writeQ));
   assign memWAddr = wbCommit ? wbAddr : addrQ;
   assign memWData = wbCommit ? wbData : dataQ;
`else
   assign startAccess = (state == StIdle) && request;
   assign idleReady   = !request;
   assign memWe       = reset && (state == StDone) && writeQ;
   assign memWAddr    = addrQ;
   assign memWData    = dataQ;
`endif

   always_comb begin
      MemReady = 1'b1;
      unique case (state)
         StIdle:  MemReady = idleReady;
         StBusy:  MemReady = 1'b0;
         StDone:  MemReady = 1'b1;
         default: MemReady = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= StIdle;
         count     <= 4'd0;
         addrQ     <= '0;
         dataQ     <= '0;
         writeQ    <= 1'b0;
         ReadDataM <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (startAccess) begin
                  addrQ  <= wordIdx;
                  dataQ  <= WriteDataM;
                  writeQ <= MemWriteM;
                  count  <= LAT_M1;
                  state  <= StBusy;
               end
            end
            StBusy: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  state <= StDone;
                  // Load result is registered on entry to DONE so it is visible during DONE.
                  if (!writeQ) ReadDataM <= mem[addrQ];
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) mem[memWAddr] <= memWData;
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus random traffic against an
// array-based memory model with a cycle-level stall predictor (posted-buffer aware).
module tb_data_memory_ctrl;

   localparam int unsigned L  = 3;
   localparam int unsigned DL = 8;
`ifdef DMEM_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWriteM = 1'b0;
   logic        MemReadM = 1'b0;
   logic [31:0] ALUOutM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        MemReady;

   data_memory_ctrl #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .MemReadM   (MemReadM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .MemReady   (MemReady)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [256];
   logic [31:0] lastRead = '0;
   int          wbFree = 0;   // first cycle index at which the posted buffer is empty

   // One complete access; predicts stalls and ReadDataM from the memory model.
   task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                         input string name);
      int stalls;
      int r0;
      int waitCyc;
      int expStalls;
      int idx;
      bit done;
      logic [31:0] rd;
      @(negedge clk);
      MemWriteM  = w;
      MemReadM   = r;
      ALUOutM    = a;
      WriteDataM = d;
      #1;
      r0 = cyc;
      stalls = 0;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (MemReady === 1'b1) begin
            done = 1'b1;
            break;
         end
         stalls++;
         @(negedge clk);
         #1;
      end
      rd = ReadDataM;
      idx = int'(a[DL+1:2]);
      waitCyc = (WBUF && (wbFree > r0)) ? wbFree - r0 : 0;
      if (w) begin
         if (WBUF) begin
            expStalls = waitCyc;
            wbFree = r0 + waitCyc + L + 2;
         end else begin
            expStalls = L + 1;
         end
         model[idx] = d;
      end else begin
         expStalls = waitCyc + L + 1;
         lastRead = model[idx];
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: MemReady never rose, got %0d stall cycles, want %0d", name, stalls,
                  expStalls);
      end else if (stalls != expStalls) begin
         errors++;
         $display("FAIL %s stalls: got %0d want %0d", name, stalls, expStalls);
      end
      checks++;
      if (rd !== lastRead) begin
         errors++;
         $display("FAIL %s ReadDataM: got %h want %h", name, rd, lastRead);
      end
      @(posedge clk);
   endtask

   // Idle cycles with no request: controller must report ready.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         MemWriteM = 1'b0;
         MemReadM  = 1'b0;
         #1;
         checks++;
         if (MemReady !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", MemReady);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (MemReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", MemReady);
      end
      checks++;
      if (ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 00000000", ReadDataM);
      end
      @(negedge clk);
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_read_latency();
      access(1'b1, 1'b0, 32'h14, 32'hDEADBEEF, "rd_lat_setup");
      idle(1);
      access(1'b0, 1'b1, 32'h14, 32'h0, "rd_lat");
      idle(1);
   endtask

   task automatic test_write_read();
      access(1'b1, 1'b0, 32'h20, 32'h12345678, "wr_0x20");
      access(1'b0, 1'b1, 32'h20, 32'h0, "rd_0x20");
      idle(1);
      access(1'b1, 1'b0, 32'h10, 32'h77, "wr_0x10");
      access(1'b0, 1'b1, 32'h10, 32'h0, "rd_0x10_next");
      idle(2);
   endtask

   task automatic test_alias();
      access(1'b1, 1'b0, 32'h403, 32'hA5A5A5A5, "alias_wr");
      idle(1);
      access(1'b0, 1'b1, 32'h000, 32'h0, "alias_rd");
      access(1'b0, 1'b1, 32'hFFFF_FC00, 32'h0, "alias_rd_hi");
      idle(1);
   endtask

   task automatic test_both();
      access(1'b0, 1'b1, 32'h20, 32'h0, "both_pre");
      access(1'b1, 1'b1, 32'hC, 32'h9, "both_wr");
      idle(1);
      access(1'b0, 1'b1, 32'hC, 32'h0, "both_rd");
      idle(1);
   endtask

   task automatic test_back_to_back();
      access(1'b0, 1'b1, 32'h14, 32'h0, "b2b_rd0");
      access(1'b0, 1'b1, 32'h14, 32'h0, "b2b_rd1");
      access(1'b1, 1'b0, 32'h30, 32'h0BADF00D, "b2b_wr0");
      access(1'b1, 1'b0, 32'h34, 32'h600DF00D, "b2b_wr1");
      access(1'b0, 1'b1, 32'h30, 32'h0, "b2b_rd2");
      access(1'b0, 1'b1, 32'h34, 32'h0, "b2b_rd3");
      idle(1);
   endtask

   task automatic test_reset_mid();
      access(1'b1, 1'b0, 32'h8, 32'hCAFE0002, "rst_mid_setup");
      access(1'b0, 1'b1, 32'h8, 32'h0, "rst_mid_setup_rd");
      @(negedge clk);
      MemWriteM  = 1'b1;
      MemReadM   = 1'b0;
      ALUOutM    = 32'h8;
      WriteDataM = 32'h1;
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      MemWriteM = 1'b0;
      #1;
      checks++;
      if (MemReady !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got %b want 1", MemReady);
      end
      checks++;
      if (ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_rdata: got %h want 00000000", ReadDataM);
      end
      @(negedge clk);
      reset = 1'b1;
      lastRead = '0;
      wbFree = 0;
      idle(2);
      access(1'b0, 1'b1, 32'h8, 32'h0, "rst_mid_ram");
      idle(1);
   endtask

   task automatic test_random();
      logic [31:0] a;
      int op;
      for (int i = 0; i < 16; i++) begin
         a = $urandom();
         a[9:2] = 8'(i + 64);
         access(1'b1, 1'b0, a, $urandom(), "rnd_init");
      end
      for (int i = 0; i < 60; i++) begin
         a = $urandom();
         a[9:2] = 8'($urandom_range(64, 79));
         op = int'($urandom_range(0, 2));
         access(op != 0, op != 1, a, $urandom(), "rnd_op");
         idle(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_latency();
      test_write_read();
      test_alias();
      test_both();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, meaning the number of stall cycles per access before the completion cycle; legal range 1 to 15.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the word count of the internal RAM (256 x 32).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 Port MemWriteM, input, 1 bit: store request from the memory stage.
REQ-006 Port MemReadM, input, 1 bit: load request from the memory stage (MemtoRegM).
REQ-007 Port ALUOutM, input, 32 bits: byte address.
REQ-008 Port WriteDataM, input, 32 bits: store data.
REQ-009 Port ReadDataM, output, 32 bits: load data to the writeback buffer.
REQ-010 Port MemReady, output, 1 bit: 1 = the access in M completes this cycle or there is no access; 0 = the hazard unit must stall.

Function
REQ-011 The word index SHALL be ALUOutM[DEPTH_LOG2+1:2]; ALUOutM[1:0] and the upper bits are ignored, with no alignment check.
REQ-012 The controller SHALL be an FSM with states IDLE, BUSY and DONE, plus a 4-bit down-counter.
REQ-013 A request is MemReadM|MemWriteM; if both are 1, the request SHALL be treated as a write.
REQ-014 IDLE, no request: MemReady=1 and the state is held.
REQ-015 IDLE with a request: MemReady=0 combinationally in the same cycle; the address, data and type SHALL be latched; counter=LATENCY-1; next state BUSY.
REQ-016 BUSY: MemReady=0; when counter!=0 the counter decrements; when counter==0 the next state is DONE.
REQ-017 DONE: MemReady=1; the read data SHALL be driven on ReadDataM during DONE; the next state is IDLE unconditionally.
REQ-018 A write SHALL commit to RAM at the clock edge leaving DONE.
REQ-019 Stalls per access SHALL be LATENCY+1 cycles (IDLE-request cycle plus LATENCY BUSY cycles), followed by the DONE cycle.
REQ-020 ReadDataM SHALL be a register, updated only on read completion and held otherwise, including across writes.
REQ-021 Inputs SHALL be ignored in BUSY and DONE; the latched copy is used.
REQ-022 A request still present in IDLE after DONE, because the pipeline was stalled externally, SHALL start a new access; repeated accesses are idempotent.

Reset
REQ-023 While reset=0: state=IDLE, counter=0, ReadDataM=0, and MemReady=1 when no request is present.
REQ-024 RAM contents SHALL NOT be reset.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the access; a pending write SHALL NOT commit.

Configuration
REQ-026 Macro DMEM_WBUF_EN SHALL select a one-entry posted write buffer.
REQ-027 Without DMEM_WBUF_EN, writes SHALL follow REQ-015 to REQ-019 exactly like reads.
REQ-028 With DMEM_WBUF_EN, a write in IDLE with the buffer empty SHALL be captured into the buffer with MemReady=1 (zero stall).
REQ-029 With DMEM_WBUF_EN, the buffer SHALL drain in the background and commit to RAM LATENCY+1 cycles after capture, then become empty.
REQ-030 With DMEM_WBUF_EN, a read or write arriving while the buffer is occupied SHALL hold MemReady=0 until the drain commits, then proceed normally: the read per REQ-015, or the write captured into the buffer.
REQ-031 With DMEM_WBUF_EN, reset SHALL empty the buffer without committing.

Verification
REQ-032 Read with LATENCY=3: RAM[5]=0xDEADBEEF, MemReadM=1, ALUOutM=0x14 at cycle 0 -> MemReady=0 cycles 0-3, MemReady=1 with ReadDataM=0xDEADBEEF at cycle 4, IDLE at cycle 5.
REQ-033 Write then read, no macro: write 0x12345678 to 0x20, then read 0x20 -> each access stalls 4 cycles; the read returns 0x12345678.
REQ-034 Address aliasing: write 0xA5A5A5A5 to 0x403 (DEPTH_LOG2=8) -> a read of 0x000 returns 0xA5A5A5A5.
REQ-035 Reset mid-operation: reset=0 for 1 cycle during BUSY of a write of 0x1 to 0x8 -> the state returns to IDLE, ReadDataM=0, and RAM[2] is unchanged.
REQ-036 With DMEM_WBUF_EN: a write of 0x77 to 0x10 gives MemReady=1 at capture; a read of 0x10 in the next cycle stalls until the drain commits plus 4 cycles, then returns 0x77.
REQ-037 Simultaneous MemReadM=MemWriteM=1 with WriteDataM=0x9 to 0xC -> treated as a write, RAM[3]=0x9, and ReadDataM is unchanged.
